serial_adder: RTL and testbench

- Bit-serial N-bit adder, the additive counterpart to the team's half/full subtractor blocks.
- Latches two operands on a start request, then processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Presents the N-bit sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in slow control paths.

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first, N cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sh, b_sh;
  // Holds the N-1 bits already produced; the Nth bit is appended directly at completion.
  logic [N-2:0]   psum;
  logic           c;
  logic           s, c_n, last;

  assign s    = a_sh[0] ^ b_sh[0] ^ c;
  assign c_n  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last = (cnt == CW'(N-1));
  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      psum <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          psum <= (psum >> 1) | ((N-1)'(s) << (N-2));
          c    <= c_n;
          cnt  <= cnt + CW'(1);
          done <= last;
          if (last) begin
            sum  <= {s, psum};
            cout <= c_n;
`ifdef SERIAL_ADDER_OVF_EN
            // c is the carry into the MSB on this edge, c_n the carry out of it.
            ovf  <= c ^ c_n;
`endif
          end
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=4): directed cases, exhaustive sweep, random back-to-back runs.
module tb_serial_adder;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout, busy, done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] prev_sum;
  logic         prev_cout;

  serial_adder #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues one add from the current negedge and checks the whole run against plain arithmetic.
  // Ends at the negedge where done should be high. ign_start re-pulses start mid-run.
  task automatic op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                    input logic tc, input bit ign_start, input bit full);
    logic [N:0] ref_v;
    logic       ref_ovf;
    ref_v   = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tc};
    ref_ovf = (ta[N-1] == tb[N-1]) && (ref_v[N-1] != ta[N-1]);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(negedge clk);
    start = 1'b0; a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    if (full) chk({tag, "_busy0"}, busy, 1'b1);
    for (int j = 1; j < N; j++) begin
      if (ign_start && j == 2) begin
        start = 1'b1; a = 4'h7; b = 4'h7;
      end
      @(negedge clk);
      start = 1'b0;
      if (full) begin
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_hold"}, {cout, sum}, {prev_cout, prev_sum});
      end
      chk({tag, "_nodone"}, done, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_res"}, {cout, sum}, ref_v);
    if (full) chk({tag, "_idle"}, busy, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, ovf, ref_ovf);
`endif
    prev_sum  = ref_v[N-1:0];
    prev_cout = ref_v[N];
  endtask

  task automatic idle_chk(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk({tag, "_nodone"}, done, 1'b0);
      chk({tag, "_hold"}, {cout, sum}, {prev_cout, prev_sum});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    #12;
    chk("rst_out", {cout, sum, busy, done}, '0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    op("basic", 4'h3, 4'h5, 1'b0, 1'b0, 1'b1);
    idle_chk("basic_after", 1);
    op("wrap", 4'hF, 4'h1, 1'b0, 1'b0, 1'b1);
    idle_chk("wrap_after", 1);
    op("wrap_cin", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
    idle_chk("wrap_cin_after", 1);
    op("ignore", 4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
    idle_chk("ignore_after", N + 2);

    // Back-to-back: next start lands in the done cycle.
    op("b2b_a", 4'h9, 4'h4, 1'b0, 1'b0, 1'b1);
    op("b2b_b", 4'h6, 4'h2, 1'b0, 1'b0, 1'b1);
    idle_chk("b2b_after", 1);

    // Reset after two RUN edges discards the run and clears the outputs.
    start = 1'b1; a = 4'h9; b = 4'h9; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", {cout, sum, busy, done}, '0);
    prev_sum = '0; prev_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_chk("midrst_after", N + 2);
    op("post_rst", 4'h2, 4'h3, 1'b0, 1'b0, 1'b1);
    idle_chk("post_rst_after", 1);

    // Reset released with start already high: accepted on the first edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    prev_sum = '0; prev_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op("rst_start", 4'hA, 4'h7, 1'b1, 1'b0, 1'b1);
    idle_chk("rst_start_after", 1);

    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      op("exh", vv[3:0], vv[7:4], vv[8], 1'b0, 1'b0);
      @(negedge clk);
    end

    for (int r = 0; r < 100; r++) begin
      op("rnd", N'($urandom), N'($urandom), 1'($urandom), 1'b0, 1'b1);
      if ($urandom_range(1, 0) == 1) idle_chk("rnd_gap", $urandom_range(3, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
